ps2_key_event_decoder: RTL and testbench
========================================

// Module: ps2_key_event_decoder
// PURPOSE
//  Consumes the 16-bit {previous byte, current byte} keycode pair from the PS/2 receiver and turns it into discrete key events.
//  Resynchronises the pair into the system clock domain and decodes make, break and extended (E0) codes.
//  Buffers events in a small FIFO with a valid/ready interface and maintains modifier status.
//  Sits between the PS/2 receiver and the application logic (display/control FSM).
// PARAMETERS
//  STABLE_CYCLES  16  clk cycles the synchronised keycode must hold unchanged before it is accepted (>=2)
//  FIFO_DEPTH     8   event FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous active-high reset
//  keycode    in   16  {prev, cur} bytes from the receiver; asynchronous to clk
//  evt_ready  in   1   consumer accepts the head event this cycle
//  ovf_clr    in   1   clears the overflow flag
//  evt_valid  out  1   FIFO non-empty
//  evt_data   out  10  {ext, brk, code[7:0]} of the FIFO head
//  shift      out  1   left (12h) or right (59h) shift held
//  ctrl       out  1   ctrl (14h, either side) held
//  alt        out  1   alt (11h, either side) held
//  overflow   out  1   sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset, async, all cleared:
//   - evt_valid=0, evt_data=0, shift=ctrl=alt=0, overflow=0
//   - FIFO empty; sync regs, last_acc and stable counter =0; ext_pend=0
//  Input capture:
//   - keycode passes through a 2-flop synchroniser (s1 -> s2).
//   - stab_cnt clears whenever s2 changes and otherwise counts up, saturating.
//   - Accept: s2 has been unchanged for STABLE_CYCLES cycles and s2 != last_acc.
//     One-cycle accept pulse; last_acc <= s2.
//   - A pair identical to last_acc is never re-accepted. Typematic repeats of the same code are invisible by design.
//  Decode of accepted K={hi,lo}, registered one cycle after accept:
//   - lo==E0h: ext_pend<=1. No event.
//   - lo==F0h: if hi==E0h then ext_pend<=1. No event.
//   - else if lo==00h: no event; ext_pend unchanged.
//   - else if hi==F0h: break event {ext_pend,1,lo}; ext_pend<=0.
//   - else if hi==E0h: make event {1,0,lo}; ext_pend<=0.
//   - else: make event {ext_pend,0,lo}; ext_pend<=0.
//  Modifiers:
//   - Updated on every decoded event, whether or not the FIFO accepts it.
//   - make sets the flag, break clears it. Extended ctrl/alt count as ctrl/alt.
//   - shift = shift_l | shift_r.
//  Latency: evt_valid rises STABLE_CYCLES+4 clks (+1 for sync uncertainty) after keycode settles, with the FIFO empty.
//  FIFO: first-word-fall-through.
//   - evt_data is the head entry whenever evt_valid=1; it is a don't-care when evt_valid=0.
//   - Pop on evt_valid & evt_ready.
//   - Push on decoded event.
//   - Full and no pop: event dropped, overflow<=1.
//   - Full with push and pop in the same cycle: both occur, no overflow.
//   - Empty with push: evt_valid rises next cycle; simultaneous pop is ignored.
//   - Pointers are ADDR_W+1 bits wide and wrap modulo 2*FIFO_DEPTH.
//  overflow: sticky until ovf_clr=1. Set wins if a drop and ovf_clr occur in the same cycle.
//  rst mid-frame or mid-debounce: everything returns to reset values.
//   - A keycode already present at rst release is accepted once it is stable, provided it is non-zero.
// TESTING
//  1 make: keycode 0000->001C, hold 40 clks -> one event 01Ch, ext=0, brk=0; evt_valid within STABLE_CYCLES+5 clks.
//  2 break: 001C->1CF0->F01C -> events: make 01Ch, then break {0,1,1C}; no event for 1CF0.
//  3 extended: E0->F0->75 sequence: xxE0, E0F0, F075; earlier make E075 -> make {1,0,75}, break {1,1,75}.
//  4 glitch: toggle keycode for 10 clks (<STABLE_CYCLES), then back to last_acc -> no event.
//  5 overflow: evt_ready=0, 9 distinct makes with FIFO_DEPTH=8 -> 8 events held, overflow=1.
//    Then pop all: data in order, no extra event. ovf_clr -> overflow=0.
//  6 modifiers + reset: make 12h -> shift=1. Break 12h -> shift=0. Make 14h then rst -> ctrl=0, evt_valid=0.

Source files
------------

// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 keycode pair to key event decoder with event FIFO
//
// Purpose: resynchronises the {prev, cur} keycode pair from the PS/2 receiver,
//          debounces it and decodes make/break/extended codes into key events.
//          Events are queued in a first-word-fall-through FIFO, and the
//          shift/ctrl/alt modifier state is tracked alongside.
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   keycode    in   16  {prev, cur} bytes, asynchronous to clk
//   evt_ready  in   1   consumer takes the head event this cycle
//   ovf_clr    in   1   clears the overflow flag
//   evt_valid  out  1   FIFO non-empty
//   evt_data   out  10  {ext, brk, code[7:0]} of the FIFO head
//   shift      out  1   left or right shift held
//   ctrl       out  1   ctrl held
//   alt        out  1   alt held
//   overflow   out  1   sticky event-dropped flag
module ps2_key_event_decoder #(
   parameter int STABLE_CYCLES = 16,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] keycode,
   input  logic        evt_ready,
   input  logic        ovf_clr,
   output logic        evt_valid,
   output logic [9:0]  evt_data,
   output logic        shift,
   output logic        ctrl,
   output logic        alt,
   output logic        overflow
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

   // ---------------------------------------------------------------
   // Input capture and debounce
   // ---------------------------------------------------------------
   logic [15:0]      s1, s2, last_acc, acc_key;
   logic [CNT_W-1:0] stab_cnt;
   logic             acc_cond, acc_q;

   // stab_cnt == 0 is the first cycle of a new s2 value, so reaching
   // STABLE_CYCLES-1 means s2 has held for STABLE_CYCLES cycles.
   assign acc_cond = (stab_cnt >= CNT_ACC) && (s2 != last_acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1       <= '0;
         s2       <= '0;
         stab_cnt <= '0;
         last_acc <= '0;
         acc_key  <= '0;
         acc_q    <= 1'b0;
      end else begin
         s1 <= keycode;
         s2 <= s1;
         // s1 != s2 means s2 changes on this edge
         if (s1 != s2)
            stab_cnt <= '0;
         else if (stab_cnt != CNT_MAX)
            stab_cnt <= stab_cnt + CNT_W'(1);
         acc_q <= acc_cond;
         if (acc_cond) begin
            last_acc <= s2;
            acc_key  <= s2;
         end
      end
   end

   // ---------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------
   logic [7:0] k_lo, k_hi;
   logic       ext_pend, ext_nxt;
   logic       dec_hit, dec_valid;
   logic [9:0] dec_ev, dec_data;

   assign k_lo = acc_key[7:0];
   assign k_hi = acc_key[15:8];

   always_comb begin
      dec_hit = 1'b0;
      dec_ev  = '0;
      ext_nxt = ext_pend;
      if (acc_q) begin
         if (k_lo == 8'hE0) begin
            ext_nxt = 1'b1;
         end else if (k_lo == 8'hF0) begin
            if (k_hi == 8'hE0)
               ext_nxt = 1'b1;
         end else if (k_lo != 8'h00) begin
            dec_hit = 1'b1;
            ext_nxt = 1'b0;
            if (k_hi == 8'hF0)
               dec_ev = {ext_pend, 1'b1, k_lo};
            else if (k_hi == 8'hE0)
               dec_ev = {1'b1, 1'b0, k_lo};
            else
               dec_ev = {ext_pend, 1'b0, k_lo};
         end
      end
   end

   logic shift_l, shift_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_pend  <= 1'b0;
         dec_valid <= 1'b0;
         dec_data  <= '0;
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         ctrl      <= 1'b0;
         alt       <= 1'b0;
      end else begin
         ext_pend  <= ext_nxt;
         dec_valid <= dec_hit;
         dec_data  <= dec_ev;
         // modifiers follow every decoded event, even ones the FIFO drops
         if (dec_valid) begin
            case (dec_data[7:0])
               8'h12:   shift_l <= ~dec_data[8];
               8'h59:   shift_r <= ~dec_data[8];
               8'h14:   ctrl    <= ~dec_data[8];
               8'h11:   alt     <= ~dec_data[8];
               default: ;
            endcase
         end
      end
   end

   assign shift = shift_l | shift_r;

   // ---------------------------------------------------------------
   // Event FIFO (first-word-fall-through)
   // ---------------------------------------------------------------
   logic [9:0]      mem [FIFO_DEPTH];
   logic [ADDR_W:0] wptr, rptr;
   logic            full, push, pop, drop;

   assign evt_valid = (wptr != rptr);
   assign full      = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
   // pop is gated by evt_valid, so a pop against an empty FIFO is ignored
   assign pop       = evt_valid & evt_ready;
   assign push      = dec_valid & (~full | pop);
   assign drop      = dec_valid & full & ~pop;
   assign evt_data  = evt_valid ? mem[rptr[ADDR_W-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr[ADDR_W-1:0]] <= dec_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + (ADDR_W+1)'(1);
         if (pop)
            rptr <= rptr + (ADDR_W+1)'(1);
         // a drop in the same cycle as ovf_clr keeps the flag set
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb/tb_ps2_key_event_decoder.sv - scoreboard bench for ps2_key_event_decoder
module tb_ps2_key_event_decoder;

   localparam int SC = 16;
   localparam int FD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] keycode;
   logic        evt_ready;
   logic        ovf_clr;
   logic        evt_valid;
   logic [9:0]  evt_data;
   logic        shift, ctrl, alt, overflow;

   always #5 clk = ~clk;

   ps2_key_event_decoder #(.STABLE_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
      .clk       (clk),
      .rst       (rst),
      .keycode   (keycode),
      .evt_ready (evt_ready),
      .ovf_clr   (ovf_clr),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .shift     (shift),
      .ctrl      (ctrl),
      .alt       (alt),
      .overflow  (overflow)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [9:0]  exp_q [$];
   logic [15:0] m_last;
   logic        m_ext, m_shl, m_shr, m_ctl, m_alt, m_ovf;
   int          ready_mode = 0;   // 0: never ready, 1: random, 2: always

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_last = 16'h0000;
      m_ext  = 1'b0;
      m_shl  = 1'b0;
      m_shr  = 1'b0;
      m_ctl  = 1'b0;
      m_alt  = 1'b0;
      m_ovf  = 1'b0;
   endtask

   // Reference: a newly stable pair different from the last accepted one
   // produces at most one event, following the PS/2 set-2 prefix rules.
   task automatic model_key(input logic [15:0] k);
      logic [7:0] lo, hi;
      logic       brk, e;
      logic [9:0] ev;
      if (k == m_last) return;
      m_last = k;
      lo = k[7:0];
      hi = k[15:8];
      if (lo == 8'hE0) begin
         m_ext = 1'b1;
      end else if (lo == 8'hF0) begin
         if (hi == 8'hE0) m_ext = 1'b1;
      end else if (lo != 8'h00) begin
         brk = (hi == 8'hF0);
         e   = (hi == 8'hE0) ? 1'b1 : m_ext;
         m_ext = 1'b0;
         ev = {e, brk, lo};
         if (lo == 8'h12) m_shl = !brk;
         if (lo == 8'h59) m_shr = !brk;
         if (lo == 8'h14) m_ctl = !brk;
         if (lo == 8'h11) m_alt = !brk;
         if (exp_q.size() >= FD) m_ovf = 1'b1;
         else exp_q.push_back(ev);
      end
   endtask

   task automatic apply_key(input logic [15:0] k, input int hold);
      keycode = k;
      model_key(k);
      repeat (hold) @(negedge clk);
   endtask

   task automatic chk_mods();
      chk("shift", shift, m_shl | m_shr);
      chk("ctrl", ctrl, m_ctl);
      chk("alt", alt, m_alt);
   endtask

   task automatic drain();
      ready_mode = 2;
      for (int i = 0; i < 300 && (evt_valid || exp_q.size() != 0); i++)
         @(negedge clk);
      chk("drain_pending", exp_q.size(), 0);
      chk("drain_valid", evt_valid, 1'b0);
   endtask

   // Monitor: pick this cycle's ready, then score the head if it will be popped
   always @(negedge clk) begin : monitor
      logic [9:0] e;
      case (ready_mode)
         0:       evt_ready = 1'b0;
         1:       evt_ready = 1'($urandom_range(0, 1));
         default: evt_ready = 1'b1;
      endcase
      if (!rst && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got %0h expected none", evt_data);
         end else begin
            e = exp_q.pop_front();
            chk("event", evt_data, e);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [7:0]  lo, hi;
      logic [15:0] k;
      rst     = 1'b1;
      keycode = 16'h0000;
      ovf_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_valid", evt_valid, 1'b0);
      chk("rst_data", evt_data, 10'h000);
      chk("rst_shift", shift, 1'b0);
      chk("rst_ctrl", ctrl, 1'b0);
      chk("rst_alt", alt, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // make with latency
      ready_mode = 0;
      keycode = 16'h001C;
      model_key(16'h001C);
      lat = 0;
      while (!evt_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat < SC + 4 || lat > SC + 5) begin
         bad++;
         $display("FAIL latency: got %0d expected %0d..%0d", lat, SC + 4, SC + 5);
      end
      repeat (20) @(negedge clk);

      // break
      apply_key(16'h1CF0, 40);
      apply_key(16'hF01C, 40);
      drain();

      // extended make/break
      apply_key(16'hE075, 40);
      apply_key(16'h75E0, 40);
      apply_key(16'hE0F0, 40);
      apply_key(16'hF075, 40);
      drain();

      // glitch shorter than the debounce, then back to last accepted pair
      keycode = 16'h1234;
      repeat (10) @(negedge clk);
      keycode = 16'hF075;
      repeat (40) @(negedge clk);
      drain();

      // overflow
      ready_mode = 0;
      for (int i = 0; i < FD + 1; i++)
         apply_key({8'h00, 8'h21 + 8'(i)}, 40);
      chk("ovf_set", overflow, m_ovf);
      chk("ovf_valid", evt_valid, 1'b1);
      drain();
      chk("ovf_sticky", overflow, 1'b1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      m_ovf = 1'b0;
      chk("ovf_clr", overflow, m_ovf);

      // modifiers and reset mid-debounce
      apply_key(16'h0012, 40);
      chk("shift_make", shift, 1'b1);
      apply_key(16'hF012, 40);
      chk("shift_break", shift, 1'b0);
      apply_key(16'h0014, 40);
      chk("ctrl_make", ctrl, 1'b1);
      keycode = 16'h0077;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst2_ctrl", ctrl, 1'b0);
      chk("rst2_valid", evt_valid, 1'b0);
      chk("rst2_ovf", overflow, 1'b0);
      model_reset();
      rst = 1'b0;
      apply_key(16'h0077, 40);
      chk_mods();
      drain();

      // randomized traffic
      ready_mode = 1;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            keycode = 16'($urandom);
            repeat ($urandom_range(1, 10)) @(negedge clk);
            keycode = m_last;
            repeat (SC + 8) @(negedge clk);
         end else begin
            case ($urandom_range(0, 9))
               0: lo = 8'h12;
               1: lo = 8'h59;
               2: lo = 8'h14;
               3: lo = 8'h11;
               4: lo = 8'h1C;
               5: lo = 8'h75;
               6: lo = 8'hE0;
               7: lo = 8'hF0;
               8: lo = 8'h00;
               default: lo = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
               0: hi = 8'h00;
               1: hi = 8'hF0;
               2: hi = 8'hE0;
               default: hi = 8'($urandom);
            endcase
            k = {hi, lo};
            apply_key(k, $urandom_range(SC + 8, SC + 24));
         end
         chk_mods();
      end
      drain();
      chk("final_ovf", overflow, m_ovf);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
